// File: rtl/riscv_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module riscv_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] res
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q, quo_q, dvsr_q;
  logic             op_rem, neg_quo, neg_rem;

  logic             is_signed_c, accept_c, div_zero_c, ovf_c, special_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_abs_c, b_abs_c, special_res_c;
  logic [WIDTH:0]   shifted_c, diff_c;

  // Operand decode, special-case detection and the trial subtractor.
  always_comb begin
    is_signed_c   = ~div_op[0];
    accept_c      = (state == IDLE) && start && !kill;
    div_zero_c    = (b == '0);
    ovf_c         = is_signed_c && (a == MIN_NEG) && (b == '1);
    special_c     = div_zero_c || ovf_c;
    a_neg_c       = is_signed_c && a[WIDTH-1];
    b_neg_c       = is_signed_c && b[WIDTH-1];
    a_abs_c       = a_neg_c ? (~a + WIDTH'(1)) : a;
    b_abs_c       = b_neg_c ? (~b + WIDTH'(1)) : b;
    special_res_c = '0;
    if (div_zero_c) special_res_c = div_op[1] ? a : '1;
    else if (ovf_c) special_res_c = div_op[1] ? '0 : MIN_NEG;
    shifted_c     = {rem_q, quo_q[WIDTH-1]};
    diff_c        = shifted_c - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept_c) state_next = special_c ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (kill && state != IDLE) state_next = IDLE;
  end

  // Datapath and registered outputs; res only moves on accept and on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      valid   <= 1'b0;
      res     <= '0;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      op_rem  <= 1'b0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else begin
      busy  <= (state_next != IDLE);
      valid <= (state_next == DONE);
      case (state)
        IDLE: if (accept_c) begin
          op_rem  <= div_op[1];
          neg_quo <= a_neg_c ^ b_neg_c;
          neg_rem <= a_neg_c;
          rem_q   <= '0;
          quo_q   <= a_abs_c;
          dvsr_q  <= b_abs_c;
          cnt     <= CW'(WIDTH);
          res     <= special_c ? special_res_c : '0;
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (!diff_c[WIDTH]) begin
            rem_q <= diff_c[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shifted_c[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
        end
        FIX: if (!kill) begin
          if (op_rem) res <= neg_rem ? (~rem_q + WIDTH'(1)) : rem_q;
          else        res <= neg_quo ? (~quo_q + WIDTH'(1)) : quo_q;
        end
        default: ;
      endcase
    end
  end

endmodule
